mult_sched: RTL
===============

MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter NREQ, fixed at 2, giving the requester count; other values are out of scope.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-requester multiply request, level, held by the requester until its gnt.
REQ-006 a0, b0  input  WIDTH  requester 0 multiplicand and multiplier.
REQ-007 a1, b1  input  WIDTH  requester 1 multiplicand and multiplier.
REQ-008 gnt  output  2  one-hot, one-cycle acknowledge that operands were captured.
REQ-009 done  output  2  one-hot, one-cycle result-valid strobe to the owning requester.
REQ-010 busy  output  1  high while a multiplication is in progress (states CALC and DONE).
REQ-011 p  output  2*WIDTH  unsigned product of the last completed job.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; reset state is IDLE.
REQ-013 IDLE: if any req bit is high at a clock edge, the block SHALL select one winner, capture its a/b, clear the accumulator, load step count 0, and go to CALC; otherwise it stays in IDLE.
REQ-014 Arbitration SHALL be round-robin: a sole requester wins; with both high, the requester not granted last wins; the last-winner register is updated on every grant.
REQ-015 gnt[k] SHALL be high for exactly the first cycle of CALC, for the winner k only.
REQ-016 CALC SHALL last exactly WIDTH cycles; in step i (0..WIDTH-1) acc = acc + (a zero-extended to 2*WIDTH, shifted left i) when b[i]=1, else acc holds.
REQ-017 After step WIDTH-1 the FSM SHALL go to DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-018 On entry to DONE, p SHALL be loaded with acc and done[winner] SHALL be high for that one cycle.
REQ-019 p SHALL hold its value until the next DONE; it SHALL NOT change during CALC.
REQ-020 Latency: a request accepted at edge N gives gnt high in cycle N+1 and done high in cycle N+1+WIDTH; back-to-back accepts are spaced WIDTH+2 cycles apart.
REQ-021 The arithmetic SHALL be exact, with no overflow: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
REQ-022 Zero operands SHALL still take the full WIDTH cycles, and the result SHALL be 0.
REQ-023 req SHALL be ignored in CALC and DONE; a req dropped before acceptance is lost without error.
REQ-024 Operand changes after capture SHALL NOT affect the in-flight result.
REQ-025 The request for the next job SHALL be evaluated only in IDLE, so DONE and a new accept never share a cycle.

Reset
REQ-026 On rst_n low, the block SHALL immediately set state=IDLE, gnt=0, done=0, busy=0, p=0, acc=0, and last-winner=1, so requester 0 has priority first.
REQ-027 Reset asserted mid-CALC SHALL abort the job with no done pulse; after release, the block SHALL accept a new request from IDLE.

Structure
REQ-028 A shared package mult_pkg SHALL hold the FSM state encoding and the default WIDTH constant.
REQ-029 The shift-add datapath (operand registers, accumulator, step counter) SHALL be one sub-module, mult_core, with start/step/last controls; mult_sched holds the FSM, arbiter and the p register.

Verification
REQ-030 Reset release, req=01, a0=3, b0=5 -> gnt=01 one cycle later; done=01 four cycles after gnt; p=8'h0F.
REQ-031 req=10, a1=15, b1=15 -> done=10, p=8'hE1 (225).
REQ-032 req=11 held continuously from reset -> grants alternate 01, 10, 01; each done matches its own operands; accepts are 6 cycles apart.
REQ-033 a0=0, b0=9 -> done after the full 4 CALC cycles, p=0; p keeps its previous value until that DONE.
REQ-034 rst_n pulsed low during CALC step 2 -> no done pulse, p=0; the next req=01 with a0=2, b0=7 gives p=8'h0E.
REQ-035 Change a0/b0 on the cycle after gnt -> p equals the product of the values captured at accept.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiply scheduler.
//   WIDTH_DEF       default operand width in bits
//   ST_IDLE/CALC/DONE  scheduler FSM state encoding
//   rr_winner()     two-requester round-robin pick
//   onehot2()       index to 2-bit one-hot vector
package mult_pkg;

   localparam int WIDTH_DEF = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // A sole requester wins outright. When both are asking, the one that
   // did not win last time gets the slot. The result is don't-care for req=00.
   function automatic logic rr_winner(input logic [1:0] req, input logic last_win);
      logic win;
      if (req == 2'b01) begin
         win = 1'b0;
      end else if (req == 2'b10) begin
         win = 1'b1;
      end else begin
         win = ~last_win;
      end
      return win;
   endfunction

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Requester-side bus of the multiply scheduler.
//   req       per-requester level request, held until its gnt
//   a0/b0     requester 0 multiplicand / multiplier
//   a1/b1     requester 1 multiplicand / multiplier
//   gnt       one-hot, one-cycle operand-capture acknowledge
//   done      one-hot, one-cycle result-valid strobe to the owner
//   busy      a multiplication is in progress
//   p         unsigned product of the last completed job
// master = requester side, slave = scheduler side.
interface mult_sched_if
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic [1:0]         req;
   logic [WIDTH-1:0]   a0;
   logic [WIDTH-1:0]   b0;
   logic [WIDTH-1:0]   a1;
   logic [WIDTH-1:0]   b1;
   logic [1:0]         gnt;
   logic [1:0]         done;
   logic               busy;
   logic [2*WIDTH-1:0] p;

   modport master (
      output req, a0, b0, a1, b1,
      input  gnt, done, busy, p
   );

   modport slave (
      input  req, a0, b0, a1, b1,
      output gnt, done, busy, p
   );

endinterface

// File: rtl/mult_core.sv
// Shift-add multiplier datapath: operand registers, accumulator and step
// counter. One partial product is added per step, LSB of the multiplier first.
//   clk, rst_n  system clock, async active-low reset
//   start       capture a_in/b_in, clear accumulator, step count to 0
//   step        perform one shift-add step and advance the step count
//   a_in, b_in  operands to capture on start
//   last        the current step is the final one (step count = WIDTH-1)
//   acc_next    accumulator value after the current step
module mult_core
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               last,
   output logic [2*WIDTH-1:0] acc_next
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   step_cnt;
   logic [2*WIDTH-1:0] addend;

   // Partial product for this step: a zero-extended, weighted by the bit position.
   assign addend   = {{WIDTH{1'b0}}, a_reg} << step_cnt;
   assign acc_next = b_reg[step_cnt] ? (acc + addend) : acc;
   assign last     = (step_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         acc      <= '0;
         step_cnt <= '0;
      end else if (start) begin
         a_reg    <= a_in;
         b_reg    <= b_in;
         acc      <= '0;
         step_cnt <= '0;
      end else if (step) begin
         acc      <= acc_next;
         step_cnt <= step_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mult_sched.sv
// Two-requester multiply scheduler. Arbitrates round-robin between the
// requesters, runs the winner's job through the shift-add core over WIDTH
// cycles and returns the product on p with a done strobe to the owner.
//   clk, rst_n  system clock, async active-low reset
//   bus         requester bus (slave side), see mult_sched_if
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting; any req at an edge captures the winner's operands
// CALC    | WIDTH shift-add steps; gnt high in the first cycle
// DONE    | one cycle; p holds the result, done[owner] high
module mult_sched
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREQ  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   mult_sched_if.slave bus
);

   logic [1:0]         state;
   logic               last_win;
   logic [1:0]         gnt_q;
   logic [1:0]         done_q;
   logic [2*WIDTH-1:0] p_q;

   logic [NREQ-1:0]    req_v;
   logic               any_req;
   logic               win;
   logic               start;
   logic               step;
   logic               core_last;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;
   logic [2*WIDTH-1:0] acc_next;

   assign req_v   = bus.req;
   assign any_req = |req_v;
   assign win     = rr_winner(req_v, last_win);
   assign a_sel   = win ? bus.a1 : bus.a0;
   assign b_sel   = win ? bus.b1 : bus.b0;

   // Requests are only looked at in IDLE, so a new accept can never
   // coincide with the DONE cycle of the previous job.
   assign start = (state == ST_IDLE) && any_req;
   assign step  = (state == ST_CALC);

   mult_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .step     (step),
      .a_in     (a_sel),
      .b_in     (b_sel),
      .last     (core_last),
      .acc_next (acc_next)
   );

   // last_win doubles as the owner of the in-flight job, since it is
   // updated on every grant and not touched again until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         last_win <= 1'b1;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         p_q      <= '0;
      end else begin
         gnt_q  <= 2'b00;
         done_q <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state    <= ST_CALC;
                  last_win <= win;
                  gnt_q    <= onehot2(win);
               end
            end
            ST_CALC: begin
               if (core_last) begin
                  state  <= ST_DONE;
                  // Take the post-step value so the final partial product is included.
                  p_q    <= acc_next;
                  done_q <= onehot2(last_win);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.done = done_q;
   assign bus.busy = (state == ST_CALC) || (state == ST_DONE);
   assign bus.p    = p_q;

endmodule
